// File: rtl/tmds_rx_channel.sv
// TMDS receive channel: finds the 10-bit word boundary from control-token runs,
// then decodes each word into DE, data byte and control bits at pixel clock.
module tmds_rx_channel #(
  parameter int CTRL_RUN  = 128,
  parameter int CTRL_MIN  = 8,
  parameter int TIMEOUT   = 8192,
  parameter int SLIP_WAIT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] raw_word,
  output logic       bitslip,
  output logic       locked,
  output logic       de,
  output logic [7:0] data,
  output logic [1:0] ctrl,
  output logic [7:0] slip_count
);

  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam int RW = $clog2(CTRL_RUN) + 1;

  localparam logic [WW-1:0] WAIT_LAST   = WW'(TIMEOUT - 1);
  localparam logic [WW-1:0] SETTLE_LAST = WW'(SLIP_WAIT - 1);
  localparam logic [RW-1:0] RUN_LOCK    = RW'(CTRL_RUN);
  localparam logic [RW-1:0] RUN_MIN     = RW'(CTRL_MIN);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SLIP   = 2'd1,
    SETTLE = 2'd2,
    LOCKED = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [RW-1:0] run_cnt, run_next, run_inc;
  logic [WW-1:0] wait_cnt, wait_next;

  logic          is_token;
  logic [1:0]    token_ctrl;
  logic [7:0]    q;
  logic [7:0]    dec_data;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    is_token   = 1'b1;
    token_ctrl = 2'b00;
    case (raw_word)
      10'b1101010100: token_ctrl = 2'b00;
      10'b0010101011: token_ctrl = 2'b01;
      10'b0101010100: token_ctrl = 2'b10;
      10'b1010101011: token_ctrl = 2'b11;
      default:        is_token   = 1'b0;
    endcase
  end

  // TMDS transition-minimised decode; bit 9 undoes the DC-balance inversion,
  // bit 8 selects XOR or XNOR chaining.
  always_comb begin
    q           = raw_word[9] ? ~raw_word[7:0] : raw_word[7:0];
    dec_data    = '0;
    dec_data[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      dec_data[i] = raw_word[8] ? (q[i-1] ^ q[i]) : ~(q[i-1] ^ q[i]);
    end
  end

  assign run_inc = (run_cnt >= RUN_LOCK) ? run_cnt : run_cnt + RW'(1);

  always_comb begin
    state_next = state;
    run_next   = is_token ? run_inc : '0;
    wait_next  = wait_cnt + WW'(1);
    case (state)
      HUNT: begin
        // Lock is checked first so it wins over a coincident timeout.
        if (is_token && run_inc >= RUN_LOCK) begin
          state_next = LOCKED;
          wait_next  = '0;
        end else if (wait_cnt == WAIT_LAST) begin
          state_next = SLIP;
          wait_next  = '0;
        end
      end
      SLIP: begin
        state_next = SETTLE;
        run_next   = '0;
        wait_next  = '0;
      end
      SETTLE: begin
        run_next = '0;
        if (wait_cnt == SETTLE_LAST) begin
          state_next = HUNT;
          wait_next  = '0;
        end
      end
      LOCKED: begin
        // A blanking run of CTRL_MIN tokens or longer keeps the watchdog fed.
        if (run_next >= RUN_MIN) begin
          wait_next = '0;
        end else if (wait_cnt == WAIT_LAST) begin
          state_next = HUNT;
          run_next   = '0;
          wait_next  = '0;
        end
      end
      default: begin
        state_next = HUNT;
        run_next   = '0;
        wait_next  = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; the reset branch is synchronous.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= HUNT;
      run_cnt    <= '0;
      wait_cnt   <= '0;
      bitslip    <= 1'b0;
      slip_count <= '0;
      locked     <= 1'b0;
      de         <= 1'b0;
      data       <= '0;
      ctrl       <= '0;
    end else begin
      state    <= state_next;
      run_cnt  <= run_next;
      wait_cnt <= wait_next;

      // The pulse is registered from the SLIP state, landing one cycle after it.
      bitslip <= (state == SLIP);
      if (state == SLIP && slip_count != 8'hFF) begin
        slip_count <= slip_count + 8'd1;
      end

      locked <= (state_next == LOCKED);
      if (state_next == LOCKED) begin
        de   <= ~is_token;
        data <= is_token ? 8'h00 : dec_data;
        ctrl <= is_token ? token_ctrl : 2'b00;
      end else begin
        de   <= 1'b0;
        data <= '0;
        ctrl <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tmds_rx_channel.sv
// Self-checking bench for tmds_rx_channel: alignment, decode, slip timing,
// lock loss and reset, against a behavioural reference kept in the bench.
module tb_tmds_rx_channel;

  localparam int CTRL_RUN  = 128;
  localparam int CTRL_MIN  = 8;
  localparam int TIMEOUT   = 8192;
  localparam int SLIP_WAIT = 8;

  localparam logic [9:0] C0 = 10'b1101010100;
  localparam logic [9:0] C1 = 10'b0010101011;
  localparam logic [9:0] C2 = 10'b0101010100;
  localparam logic [9:0] C3 = 10'b1010101011;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] raw_word = '0;
  logic       bitslip;
  logic       locked;
  logic       de;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic [7:0] slip_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [9:0] tokens [4] = '{C0, C1, C2, C3};

  tmds_rx_channel #(
    .CTRL_RUN (CTRL_RUN),
    .CTRL_MIN (CTRL_MIN),
    .TIMEOUT  (TIMEOUT),
    .SLIP_WAIT(SLIP_WAIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_word  (raw_word),
    .bitslip   (bitslip),
    .locked    (locked),
    .de        (de),
    .data      (data),
    .ctrl      (ctrl),
    .slip_count(slip_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic bit ref_is_token(input logic [9:0] w, output logic [1:0] c);
    c = 2'b00;
    for (int k = 0; k < 4; k++) begin
      if (w == tokens[k]) begin
        c = 2'(k);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // Each output bit is the XOR of adjacent bits; XNOR chaining flips bits 7..1.
  function automatic logic [7:0] ref_data(input logic [9:0] w);
    logic [7:0] qq;
    logic [7:0] r;
    qq = w[9] ? ~w[7:0] : w[7:0];
    r  = qq ^ {qq[6:0], 1'b0};
    return w[8] ? r : (r ^ 8'hFE);
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] w;
    logic [1:0] c;
    w = 10'($urandom);
    while (ref_is_token(w, c)) w = 10'($urandom);
    return w;
  endfunction

  // Serial stream of repeated C0 seen through a deserializer offset by o bits.
  function automatic logic [9:0] rot_c0(input int o);
    int v;
    v = int'(C0);
    return 10'(((v >> o) | (v << (10 - o))) & 1023);
  endfunction

  task automatic step(input logic [9:0] w);
    raw_word = w;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (4) step(10'($urandom));
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(10'($urandom));
      checks++;
      if ({bitslip, locked, de, data, ctrl, slip_count} !== 21'd0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got bitslip=%b locked=%b de=%b data=%h ctrl=%b slip_count=%0d, required all 0",
                 i, bitslip, locked, de, data, ctrl, slip_count);
      end
    end
    rst_n = 1'b1;
    cyc = 0;
    step(10'($urandom));
    checks++;
    if ({bitslip, locked, de, data, ctrl, slip_count} !== 21'd0) begin
      errors++;
      $display("FAIL reset_release: got bitslip=%b locked=%b de=%b data=%h ctrl=%b slip_count=%0d, required all 0",
               bitslip, locked, de, data, ctrl, slip_count);
    end
  endtask

  task automatic test_aligned_lock();
    do_reset();
    for (int i = 0; i < CTRL_RUN; i++) begin
      step(C0);
      if (i == CTRL_RUN - 2) begin
        checks++;
        if (locked !== 1'b0) begin
          errors++;
          $display("FAIL lock_early: locked=%b after %0d tokens, required 0", locked, i + 1);
        end
      end
    end
    checks++;
    if (locked !== 1'b1 || de !== 1'b0 || ctrl !== 2'b00) begin
      errors++;
      $display("FAIL lock_aligned: locked=%b de=%b ctrl=%b, required locked=1 de=0 ctrl=00", locked, de, ctrl);
    end
    step(10'h100);
    checks++;
    if (locked !== 1'b1 || de !== 1'b1 || data !== 8'h00 || slip_count !== 8'd0) begin
      errors++;
      $display("FAIL first_data: locked=%b de=%b data=%h slip_count=%0d, required 1 1 00 0",
               locked, de, data, slip_count);
    end
  endtask

  task automatic test_decode();
    logic [9:0] w;
    logic [1:0] c;
    bit         tok;
    step(C3);
    checks++;
    if (de !== 1'b0 || ctrl !== 2'b11) begin
      errors++;
      $display("FAIL decode_c3: de=%b ctrl=%b, required de=0 ctrl=11", de, ctrl);
    end
    step(10'h200);
    checks++;
    if (de !== 1'b1 || data !== 8'hFF) begin
      errors++;
      $display("FAIL decode_200: de=%b data=%h, required de=1 data=ff", de, data);
    end
    for (int i = 0; i < 400; i++) begin
      w = ($urandom_range(3, 0) == 0) ? tokens[$urandom_range(3, 0)] : 10'($urandom);
      step(w);
      tok = ref_is_token(w, c);
      checks++;
      if (locked !== 1'b1 || de !== !tok || (tok && ctrl !== c) || (!tok && data !== ref_data(w))) begin
        errors++;
        $display("FAIL decode_rand[%0d] word=%b: locked=%b de=%b data=%h ctrl=%b, required locked=1 de=%b data=%h ctrl=%b",
                 i, w, locked, de, data, ctrl, !tok, ref_data(w), c);
      end
    end
  endtask

  task automatic test_misalignment();
    int offset;
    int pulses[$];
    int lock_cyc;
    int exp_p[3];
    int exp_lock;
    offset   = 3;
    lock_cyc = -1;
    exp_p[0] = TIMEOUT + 1;
    exp_p[1] = exp_p[0] + TIMEOUT + SLIP_WAIT + 1;
    exp_p[2] = exp_p[1] + TIMEOUT + SLIP_WAIT + 1;
    exp_lock = exp_p[2] + SLIP_WAIT + CTRL_RUN;
    do_reset();
    while (lock_cyc < 0 && cyc < exp_lock + 50) begin
      step(rot_c0(offset));
      if (bitslip === 1'b1) begin
        pulses.push_back(cyc);
        offset = (offset + 9) % 10;
      end
      if (locked === 1'b1) lock_cyc = cyc;
    end
    checks++;
    if (pulses.size() != 3) begin
      errors++;
      $display("FAIL slip_pulses: saw %0d bitslip pulses, required 3", pulses.size());
    end
    for (int i = 0; i < 3 && i < pulses.size(); i++) begin
      checks++;
      if (pulses[i] != exp_p[i]) begin
        errors++;
        $display("FAIL slip_time[%0d]: pulse at cycle %0d, required %0d", i, pulses[i], exp_p[i]);
      end
    end
    checks++;
    if (lock_cyc != exp_lock || slip_count !== 8'd3) begin
      errors++;
      $display("FAIL misalign_lock: locked at cycle %0d slip_count=%0d, required cycle %0d slip_count=3",
               lock_cyc, slip_count, exp_lock);
    end
  endtask

  task automatic test_near_miss();
    bit early;
    bit slipped;
    early   = 1'b0;
    slipped = 1'b0;
    do_reset();
    for (int i = 0; i < CTRL_RUN - 1; i++) begin
      step(C1);
      if (locked !== 1'b0) early = 1'b1;
      if (bitslip !== 1'b0) slipped = 1'b1;
    end
    step(10'h100);
    if (locked !== 1'b0) early = 1'b1;
    for (int i = 0; i < CTRL_RUN; i++) begin
      step(C1);
      if (i < CTRL_RUN - 1 && locked !== 1'b0) early = 1'b1;
      if (bitslip !== 1'b0) slipped = 1'b1;
    end
    checks++;
    if (early || slipped) begin
      errors++;
      $display("FAIL near_miss_early: early_lock=%b bitslip_seen=%b, required 0 0", early, slipped);
    end
    checks++;
    if (locked !== 1'b1 || de !== 1'b0 || ctrl !== 2'b01) begin
      errors++;
      $display("FAIL near_miss_lock: locked=%b de=%b ctrl=%b, required 1 0 01", locked, de, ctrl);
    end
  endtask

  task automatic test_lock_loss();
    bit lost_early;
    bit relock;
    int loss_cyc;
    int exp_pulse;
    int pulse_cyc;
    lost_early = 1'b0;
    relock     = 1'b0;
    pulse_cyc  = -1;
    do_reset();
    repeat (CTRL_RUN) step(C0);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL loss_setup: locked=%b, required 1", locked);
    end
    for (int i = 1; i < TIMEOUT; i++) begin
      step(rand_data());
      if (locked !== 1'b1) lost_early = 1'b1;
    end
    checks++;
    if (lost_early) begin
      errors++;
      $display("FAIL loss_early: locked dropped before %0d data words, required held", TIMEOUT);
    end
    step(rand_data());
    checks++;
    if (locked !== 1'b0 || de !== 1'b0 || data !== 8'h00 || ctrl !== 2'b00) begin
      errors++;
      $display("FAIL lock_loss: locked=%b de=%b data=%h ctrl=%b, required all 0", locked, de, data, ctrl);
    end
    loss_cyc  = cyc;
    exp_pulse = loss_cyc + TIMEOUT + 1;
    while (pulse_cyc < 0 && cyc < exp_pulse + 20) begin
      step(rand_data());
      if (bitslip === 1'b1) pulse_cyc = cyc;
      if (locked !== 1'b0) relock = 1'b1;
    end
    checks++;
    if (pulse_cyc != exp_pulse || relock) begin
      errors++;
      $display("FAIL hunt_after_loss: pulse at cycle %0d relock=%b, required cycle %0d relock=0",
               pulse_cyc, relock, exp_pulse);
    end
    checks++;
    if (slip_count !== 8'd1) begin
      errors++;
      $display("FAIL slip_count_one: slip_count=%0d, required 1", slip_count);
    end
    repeat (3) step(rand_data());
    rst_n = 1'b0;
    step(C0);
    checks++;
    if (bitslip !== 1'b0 || slip_count !== 8'd0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_settle: bitslip=%b slip_count=%0d locked=%b, required 0 0 0",
               bitslip, slip_count, locked);
    end
    rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < CTRL_RUN; i++) begin
      step(C0);
      if (i == CTRL_RUN - 2 && locked !== 1'b0) relock = 1'b1;
    end
    checks++;
    if (locked !== 1'b1 || relock) begin
      errors++;
      $display("FAIL relock_after_reset: locked=%b early=%b, required locked=1 early=0", locked, relock);
    end
  endtask

  initial begin
    test_reset();
    test_aligned_lock();
    test_decode();
    test_misalignment();
    test_near_miss();
    test_lock_loss();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
